// File: rtl/regfile_sweep.sv
// regfile_sweep: DATA_W x DEPTH register array with one synchronous write
// port, one registered read port, a hardware clear sweep after reset or on
// request, and out-of-range address flagging on both ports.
//
// Optional feature (define REGFILE_SWEEP_PARITY_EN):
//   - Each entry carries an even-parity bit.
//   - i_par_inj corrupts the stored parity on a write.
//   - o_rd_perr flags a mismatch alongside o_rd_valid.
//
// States:
//   ST_CLEAR | sweeping entry r_cnt to zero, all port activity ignored
//   ST_RUN   | normal read/write operation

module regfile_sweep #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 11,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr_req,
    output logic              o_busy,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
`ifdef REGFILE_SWEEP_PARITY_EN
    input  logic              i_par_inj,
    output logic              o_rd_perr,
`endif
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_addr_err
);

    // DEPTH may equal 2**ADDR_W, so the range compare needs one extra bit.
    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LP_ONE   = ADDR_W'(1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_nxt;

    logic                w_clearing;
    logic                w_run;
    logic                w_wr_in;
    logic                w_rd_in;
    logic                w_do_wr;
    logic                w_do_rd;
    logic                w_err;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                r_rd_valid;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_addr_err;

    // State register: reset forces a fresh sweep from entry 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: sweep one entry per cycle, clr_req only honoured in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_CLEAR: begin
                if (r_cnt == LP_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + LP_ONE;
                end
            end
            ST_RUN: begin
                if (i_clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output/decode logic: port activity qualified by RUN, addresses compared at full width.
    always_comb begin
        w_clearing = (r_state == ST_CLEAR);
        w_run      = (r_state == ST_RUN);
        o_busy     = w_clearing;
        w_wr_in    = ({1'b0, i_wr_addr} < LP_DEPTH);
        w_rd_in    = ({1'b0, i_rd_addr} < LP_DEPTH);
        w_do_wr    = w_run & i_wr_en & w_wr_in;
        w_do_rd    = w_run & i_rd_req;
        w_err      = w_run & ((i_wr_en & ~w_wr_in) | (i_rd_req & ~w_rd_in));
    end

    // Storage: the sweep owns the array while clearing; otherwise the write port does.
    always_ff @(posedge i_clk) begin
        if (w_clearing) begin
            r_mem[r_cnt] <= '0;
        end else if (w_do_wr) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: registered, sees the pre-write contents on a same-address collision.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_rd_valid <= w_do_rd;
            r_addr_err <= w_err;
            if (w_do_rd) begin
                r_rd_data <= w_rd_in ? r_mem[i_rd_addr] : '0;
            end
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_addr_err = r_addr_err;

`ifdef REGFILE_SWEEP_PARITY_EN
    logic r_par [DEPTH];
    logic r_rd_perr;

    // Parity storage: even parity over the data, optionally inverted for fault injection.
    always_ff @(posedge i_clk) begin
        if (w_clearing) begin
            r_par[r_cnt] <= 1'b0;
        end else if (w_do_wr) begin
            r_par[i_wr_addr] <= (^i_wr_data) ^ i_par_inj;
        end
    end

    // Parity check: pulses with rd_valid, never on out-of-range reads.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_perr <= 1'b0;
        end else if (w_do_rd && w_rd_in) begin
            r_rd_perr <= ((^r_mem[i_rd_addr]) != r_par[i_rd_addr]);
        end else begin
            r_rd_perr <= 1'b0;
        end
    end

    assign o_rd_perr = r_rd_perr;
`endif

endmodule

// File: tb/tb_regfile_sweep.sv
// Self-checking bench for regfile_sweep (default 8 x 11 configuration).
module tb_regfile_sweep;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 11;
    localparam int ADDR_W = 4;

    logic              clk     = 1'b0;
    logic              rst     = 1'b1;
    logic              clr_req = 1'b0;
    logic              wr_en   = 1'b0;
    logic              rd_req  = 1'b0;
    logic              par_inj = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              busy;
    logic              rd_valid;
    logic              addr_err;
    logic [DATA_W-1:0] rd_data;
`ifdef REGFILE_SWEEP_PARITY_EN
    logic              rd_perr;
`endif

    always #5 clk = ~clk;

    regfile_sweep #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clr_req  (clr_req),
        .o_busy     (busy),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_rd_req   (rd_req),
        .i_rd_addr  (rd_addr),
`ifdef REGFILE_SWEEP_PARITY_EN
        .i_par_inj  (par_inj),
        .o_rd_perr  (rd_perr),
`endif
        .o_rd_valid (rd_valid),
        .o_rd_data  (rd_data),
        .o_addr_err (addr_err)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              perr;
    } exp_t;

    exp_t              q[$];
    logic [DATA_W-1:0] m_mem  [16];
    logic              m_perr [16];
    int                m_busy = 0;
    int                checks = 0;
    int                errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < 16; i++) begin
            m_mem[i]  = '0;
            m_perr[i] = 1'b0;
        end
    endtask

    // One clock: drive inputs, predict, clock, then compare outputs of that edge.
    task automatic step(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                        input logic re, input logic [ADDR_W-1:0] ra, input logic clr,
                        input logic pinj = 1'b0);
        logic exp_v;
        logic exp_e;
        exp_t e;
        exp_t got;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_req  = re;
        rd_addr = ra;
        clr_req = clr;
        par_inj = pinj;
        exp_v   = 1'b0;
        exp_e   = 1'b0;
        if (m_busy == 0) begin
            exp_v = re;
            exp_e = (we && int'(wa) >= DEPTH) || (re && int'(ra) >= DEPTH);
            if (re) begin
                e.data = (int'(ra) < DEPTH) ? m_mem[ra]  : '0;
                e.perr = (int'(ra) < DEPTH) ? m_perr[ra] : 1'b0;
                q.push_back(e);
            end
            if (we && int'(wa) < DEPTH) begin
                m_mem[wa]  = wd;
                m_perr[wa] = pinj;
            end
            if (clr) m_busy = DEPTH;
        end else begin
            m_busy--;
            if (m_busy == 0) model_zero();
        end
        @(posedge clk);
        #1;
        chk("busy",     32'(busy),     32'(m_busy != 0));
        chk("rd_valid", 32'(rd_valid), 32'(exp_v));
        chk("addr_err", 32'(addr_err), 32'(exp_e));
        if (rd_valid) begin
            chk("rd_expected", 32'(q.size() > 0), 32'(1));
            if (q.size() > 0) begin
                got = q.pop_front();
                chk("rd_data", 32'(rd_data), 32'(got.data));
`ifdef REGFILE_SWEEP_PARITY_EN
                chk("rd_perr", 32'(rd_perr), 32'(got.perr));
`endif
            end
        end else if (exp_v && q.size() > 0) begin
            got = q.pop_front();
        end
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic rd(input int a);
        step(1'b0, '0, '0, 1'b1, ADDR_W'(a), 1'b0);
    endtask

    task automatic wr(input int a, input logic [DATA_W-1:0] d, input logic pinj = 1'b0);
        step(1'b1, ADDR_W'(a), d, 1'b0, '0, 1'b0, pinj);
    endtask

    initial begin
        model_zero();

        // Reset values while rst is held
        #3;
        chk("rst_busy",     32'(busy),     32'(1));
        chk("rst_rd_valid", 32'(rd_valid), 32'(0));
        chk("rst_rd_data",  32'(rd_data),  32'(0));
        chk("rst_addr_err", 32'(addr_err), 32'(0));
`ifdef REGFILE_SWEEP_PARITY_EN
        chk("rst_rd_perr",  32'(rd_perr),  32'(0));
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_busy = DEPTH;

        // 1: initial sweep, then every entry reads zero
        repeat (DEPTH) idle();
        for (int a = 0; a < DEPTH; a++) rd(a);
        idle();

        // 2: write/read, then same-cycle read-before-write
        wr(3, 8'hA5);
        rd(3);
        step(1'b1, 4'd3, 8'h5A, 1'b1, 4'd3, 1'b0);
        rd(3);

        // 3: out-of-range write and read together, then singly
        step(1'b1, 4'd11, 8'hFF, 1'b1, 4'd15, 1'b0);
        idle();
        rd(11);
        step(1'b1, 4'd15, 8'h77, 1'b1, 4'd0, 1'b0);
        for (int a = 0; a < DEPTH; a++) rd(a);

        // 4: fill, clear on request (read in the clr cycle is honoured), activity ignored during sweep
        for (int a = 0; a < DEPTH; a++) wr(a, 8'(8'h11 + a));
        for (int a = 0; a < DEPTH; a++) rd(a);
        step(1'b0, '0, '0, 1'b1, 4'd10, 1'b1);
        for (int a = 0; a < DEPTH; a++)
            step(1'b1, ADDR_W'(a), 8'hEE, 1'b1, ADDR_W'(15 - a), 1'b1);
        for (int a = 0; a < DEPTH; a++) rd(a);

        // 5: reset mid-sweep restarts it
        wr(4, 8'h3C);
        rd(4);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1);
        repeat (4) idle();
        rst = 1'b1;
        #1;
        chk("mid_rst_busy",     32'(busy),     32'(1));
        chk("mid_rst_rd_valid", 32'(rd_valid), 32'(0));
        chk("mid_rst_rd_data",  32'(rd_data),  32'(0));
        chk("mid_rst_addr_err", 32'(addr_err), 32'(0));
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_busy = DEPTH;
        q.delete();
        for (int a = 0; a < DEPTH; a++)
            step(1'b1, 4'd4, 8'h99, 1'b1, 4'd4, 1'b0);
        rd(4);
        rd(3);

`ifdef REGFILE_SWEEP_PARITY_EN
        // 6: parity injection and recovery
        wr(2, 8'h01, 1'b1);
        rd(2);
        wr(2, 8'h01, 1'b0);
        rd(2);
        rd(12);
`endif

        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
